// File: rtl/int_ctrl.sv
// Vectored interrupt controller: latches rising request edges, applies mask and
// global enable, and presents one registered request/vector pair to the CPU.
module int_ctrl #(
   parameter int unsigned N_SRC      = 4,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0040,
   parameter logic [31:0] VEC_STRIDE = 32'd4
) (
   input  logic              clk,
   input  logic              Rst_n,
   input  logic [N_SRC-1:0]  IRQ,
   input  logic              IE,
   input  logic              Mask_W,
   input  logic [N_SRC-1:0]  Mask_In,
   input  logic              INT_Ack,
   input  logic              INT_Ret,
   output logic              INT_Req,
   output logic [31:0]       INT_Vector,
   output logic [2:0]        INT_ID,
   output logic [N_SRC-1:0]  Pending,
   output logic [N_SRC-1:0]  Mask,
   output logic              In_Service
);

   // state      | meaning
   // ST_IDLE    | no request outstanding, waiting for an eligible source
   // ST_REQ     | INT_Req presented, ID/vector frozen until INT_Ack
   // ST_SERVICE | handler running, waiting for INT_Ret
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_t;

   state_t            state;
   logic [N_SRC-1:0]  irq_q;
   logic [N_SRC-1:0]  irq_rise;
   logic [N_SRC-1:0]  eligible;
   logic [N_SRC-1:0]  id_onehot;
   logic [N_SRC-1:0]  clear_vec;
   logic              any_eligible;
   logic [2:0]        grant_id;
   logic [31:0]       grant_vec;

   assign irq_rise     = IRQ & ~irq_q;
   assign eligible     = Pending & ~Mask;
   assign any_eligible = |eligible;
   assign grant_vec    = VEC_BASE + 32'(grant_id) * VEC_STRIDE;

   // Scan downwards so the lowest eligible index is the last one written.
   always_comb begin
      grant_id = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) grant_id = 3'(i);
      end
   end

   always_comb begin
      id_onehot = '0;
      for (int i = 0; i < N_SRC; i++) begin
         id_onehot[i] = (INT_ID == 3'(i));
      end
   end

   assign clear_vec = (state == ST_REQ && INT_Ack) ? id_onehot : '0;

   always_ff @(posedge clk) begin
      if (!Rst_n) begin
         state      <= ST_IDLE;
         irq_q      <= '0;
         Pending    <= '0;
         Mask       <= '1;
         INT_Req    <= 1'b0;
         INT_ID     <= '0;
         INT_Vector <= VEC_BASE;
         In_Service <= 1'b0;
      end else begin
         irq_q <= IRQ;
         // A new edge on the source being acknowledged keeps it pending.
         Pending <= (Pending & ~clear_vec) | irq_rise;
         if (Mask_W) Mask <= Mask_In;

         case (state)
            ST_IDLE: begin
               if (IE && any_eligible) begin
                  state      <= ST_REQ;
                  INT_Req    <= 1'b1;
                  INT_ID     <= grant_id;
                  INT_Vector <= grant_vec;
               end
            end
            ST_REQ: begin
               if (INT_Ack) begin
                  state      <= ST_SERVICE;
                  INT_Req    <= 1'b0;
                  In_Service <= 1'b1;
               end
            end
            ST_SERVICE: begin
               if (INT_Ret) begin
                  state      <= ST_IDLE;
                  In_Service <= 1'b0;
               end
            end
            default: begin
               state      <= ST_IDLE;
               INT_Req    <= 1'b0;
               In_Service <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed vector table for the documented scenarios, then
// randomized traffic checked against a behavioural model.
module tb_int_ctrl;
   localparam int N = 4;
   localparam logic [31:0] BASE   = 32'h0000_0040;
   localparam logic [31:0] STRIDE = 32'd4;

   logic          clk = 1'b0;
   logic          Rst_n, IE, Mask_W, INT_Ack, INT_Ret;
   logic [N-1:0]  IRQ, Mask_In;
   logic          INT_Req, In_Service;
   logic [31:0]   INT_Vector;
   logic [2:0]    INT_ID;
   logic [N-1:0]  Pending, Mask;

   always #5 clk = ~clk;

   int_ctrl #(.N_SRC(N), .VEC_BASE(BASE), .VEC_STRIDE(STRIDE)) dut (
      .clk(clk), .Rst_n(Rst_n), .IRQ(IRQ), .IE(IE), .Mask_W(Mask_W),
      .Mask_In(Mask_In), .INT_Ack(INT_Ack), .INT_Ret(INT_Ret),
      .INT_Req(INT_Req), .INT_Vector(INT_Vector), .INT_ID(INT_ID),
      .Pending(Pending), .Mask(Mask), .In_Service(In_Service)
   );

   typedef struct {
      logic          rst;
      logic [N-1:0]  irq;
      logic          ie, mw;
      logic [N-1:0]  min;
      logic          ack, ret;
      logic          req;
      logic [2:0]    id;
      logic [31:0]   vec;
      logic [N-1:0]  pend, mask;
      logic          svc;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Behavioural model: a request flag, a service flag and the latched grant.
   bit [N-1:0]  m_pend, m_mask, m_prev;
   bit          m_req, m_svc;
   int          m_id;
   logic [31:0] m_vec;

   task automatic add(input int rst, irq, ie, mw, min, ack, ret,
                      input int req, id, input logic [31:0] v,
                      input int pend, mask, svc);
      vec_t r;
      r.rst = 1'(rst); r.irq = N'(irq); r.ie = 1'(ie); r.mw = 1'(mw);
      r.min = N'(min); r.ack = 1'(ack); r.ret = 1'(ret);
      r.req = 1'(req); r.id = 3'(id); r.vec = v; r.pend = N'(pend);
      r.mask = N'(mask); r.svc = 1'(svc);
      tbl.push_back(r);
   endtask

   task automatic model_edge();
      bit [N-1:0] edges, elig, np;
      bit found;
      if (!Rst_n) begin
         m_pend = '0; m_prev = '0; m_mask = '1;
         m_req = 0; m_svc = 0; m_id = 0; m_vec = BASE;
      end else begin
         edges = IRQ & ~m_prev;
         elig  = m_pend & ~m_mask;
         np    = m_pend;
         if (m_req) begin
            if (INT_Ack) begin
               np[m_id] = 1'b0;
               m_req = 0;
               m_svc = 1;
            end
         end else if (m_svc) begin
            if (INT_Ret) m_svc = 0;
         end else if (IE && elig != 0) begin
            found = 0;
            for (int i = 0; i < N; i++) begin
               if (elig[i] && !found) begin
                  m_id = i;
                  found = 1;
               end
            end
            m_vec = BASE + m_id * STRIDE;
            m_req = 1;
         end
         m_pend = np | edges;
         m_prev = IRQ;
         if (Mask_W) m_mask = Mask_In;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic req, input logic [2:0] id,
                          input logic [31:0] v, input logic [N-1:0] pend,
                          input logic [N-1:0] mask, input logic svc);
      chk({tag, ".req"},  32'(INT_Req),    32'(req));
      chk({tag, ".id"},   32'(INT_ID),     32'(id));
      chk({tag, ".vec"},  INT_Vector,      v);
      chk({tag, ".pend"}, 32'(Pending),    32'(pend));
      chk({tag, ".mask"}, 32'(Mask),       32'(mask));
      chk({tag, ".svc"},  32'(In_Service), 32'(svc));
   endtask

   initial begin
      Rst_n = 1'b0; IRQ = '0; IE = 1'b0; Mask_W = 1'b0; Mask_In = '0;
      INT_Ack = 1'b0; INT_Ret = 1'b0;

      //   rst irq ie mw min ack ret | req id vec    pend mask svc
      add(0, 0,  0, 0, 0,  0, 0,    0, 0, 32'h40, 0,   'hF, 0); // reset
      add(1, 0,  1, 1, 0,  0, 0,    0, 0, 32'h40, 0,   0,   0); // unmask
      add(1, 4,  1, 0, 0,  0, 0,    0, 0, 32'h40, 4,   0,   0); // IRQ[2] edge
      add(1, 4,  1, 0, 0,  0, 0,    1, 2, 32'h48, 4,   0,   0); // grant 2
      add(1, 4,  1, 0, 0,  1, 0,    0, 2, 32'h48, 0,   0,   1); // ack
      add(1, 0,  1, 0, 0,  0, 1,    0, 2, 32'h48, 0,   0,   0); // ret
      add(1, 'hA,1, 0, 0,  0, 0,    0, 2, 32'h48, 'hA, 0,   0); // IRQ[3],IRQ[1]
      add(1, 'hA,1, 0, 0,  0, 0,    1, 1, 32'h44, 'hA, 0,   0); // grant 1
      add(1, 'hA,1, 0, 0,  1, 0,    0, 1, 32'h44, 8,   0,   1);
      add(1, 'hA,1, 0, 0,  0, 1,    0, 1, 32'h44, 8,   0,   0); // idle gap
      add(1, 'hA,1, 0, 0,  0, 0,    1, 3, 32'h4C, 8,   0,   0); // grant 3
      add(1, 'hA,1, 0, 0,  1, 0,    0, 3, 32'h4C, 0,   0,   1);
      add(1, 0,  1, 0, 0,  0, 1,    0, 3, 32'h4C, 0,   0,   0);
      add(1, 0,  1, 1, 1,  0, 0,    0, 3, 32'h4C, 0,   1,   0); // mask src 0
      add(1, 1,  1, 0, 0,  0, 0,    0, 3, 32'h4C, 1,   1,   0);
      add(1, 1,  1, 0, 0,  0, 0,    0, 3, 32'h4C, 1,   1,   0); // masked: no req
      add(1, 1,  1, 1, 0,  0, 0,    0, 3, 32'h4C, 1,   0,   0); // old mask used
      add(1, 1,  1, 0, 0,  0, 0,    1, 0, 32'h40, 1,   0,   0); // grant 0
      add(1, 1,  1, 0, 0,  1, 0,    0, 0, 32'h40, 0,   0,   1);
      add(1, 0,  1, 0, 0,  0, 1,    0, 0, 32'h40, 0,   0,   0);
      add(1, 2,  0, 0, 0,  0, 0,    0, 0, 32'h40, 2,   0,   0); // IE=0
      add(1, 2,  0, 0, 0,  0, 0,    0, 0, 32'h40, 2,   0,   0);
      add(1, 2,  1, 0, 0,  0, 0,    1, 1, 32'h44, 2,   0,   0);
      add(1, 2,  0, 1, 'hF,0, 0,    1, 1, 32'h44, 2,   'hF, 0); // no withdraw
      add(1, 2,  0, 0, 0,  0, 1,    1, 1, 32'h44, 2,   'hF, 0); // ret in REQ
      add(1, 2,  0, 0, 0,  1, 0,    0, 1, 32'h44, 0,   'hF, 1);
      add(1, 2,  0, 0, 0,  1, 0,    0, 1, 32'h44, 0,   'hF, 1); // ack in SERVICE
      add(1, 2,  0, 0, 0,  0, 1,    0, 1, 32'h44, 0,   'hF, 0);
      add(1, 2,  1, 0, 0,  1, 0,    0, 1, 32'h44, 0,   'hF, 0); // ack in IDLE
      add(1, 0,  1, 1, 0,  0, 0,    0, 1, 32'h44, 0,   0,   0);
      add(1, 4,  1, 0, 0,  0, 0,    0, 1, 32'h44, 4,   0,   0);
      add(1, 0,  1, 0, 0,  0, 0,    1, 2, 32'h48, 4,   0,   0);
      add(1, 4,  1, 0, 0,  1, 0,    0, 2, 32'h48, 4,   0,   1); // set wins
      add(1, 4,  1, 0, 0,  0, 1,    0, 2, 32'h48, 4,   0,   0);
      add(1, 4,  1, 0, 0,  0, 0,    1, 2, 32'h48, 4,   0,   0);
      add(1, 4,  1, 0, 0,  1, 0,    0, 2, 32'h48, 0,   0,   1); // held: no edge
      add(1, 'hE,1, 0, 0,  0, 0,    0, 2, 32'h48, 'hA, 0,   1);
      add(0, 0,  1, 0, 0,  0, 0,    0, 0, 32'h40, 0,   'hF, 0); // reset in SERVICE
      add(1, 0,  1, 0, 0,  0, 0,    0, 0, 32'h40, 0,   'hF, 0);

      for (int r = 0; r < tbl.size(); r++) begin
         Rst_n = tbl[r].rst; IRQ = tbl[r].irq; IE = tbl[r].ie;
         Mask_W = tbl[r].mw; Mask_In = tbl[r].min;
         INT_Ack = tbl[r].ack; INT_Ret = tbl[r].ret;
         step();
         chk_all($sformatf("row%0d", r), tbl[r].req, tbl[r].id, tbl[r].vec,
                 tbl[r].pend, tbl[r].mask, tbl[r].svc);
      end

      for (int k = 0; k < 3000; k++) begin
         Rst_n   = ($urandom_range(299) != 0);
         IRQ     = IRQ ^ N'($urandom & $urandom);
         IE      = ($urandom_range(7) != 0);
         Mask_W  = ($urandom_range(9) == 0);
         Mask_In = N'($urandom);
         INT_Ack = ($urandom_range(2) == 0);
         INT_Ret = ($urandom_range(3) == 0);
         step();
         chk_all("rand", m_req, 3'(m_id), m_vec, m_pend, m_mask, m_svc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
